operaters_stat: RTL and testbench

Windowed statistics stage that sits directly downstream of `operaters` and consumes its 8-bit `po_a` output stream. It collects a fixed window of 2^WIN_LOG2 qualified samples and produces the window's sum, minimum, maximum, truncated average and value-change count. All results come out together with a one-cycle valid strobe, then the next window starts immediately. Results are held stable between windows for the software-visible status block and debug taps.

---
 rtl/operaters_stat.sv | 98 +++++++++
 tb/tb_operaters_stat.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/operaters_stat.sv
// Windowed statistics over 2^WIN_LOG2 qualified samples of the upstream po_a stream.
// The window's sum/min/max/avg/change-count are published together with a one-cycle valid strobe.
module operaters_stat #(
    parameter int WIN_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pi_en,
    input  logic [7:0]            pi_a,
    output logic [8+WIN_LOG2-1:0] po_sum,
    output logic [7:0]            po_min,
    output logic [7:0]            po_max,
    output logic [7:0]            po_avg,
    output logic [WIN_LOG2:0]     po_chg,
    output logic                  po_valid
);

    localparam int SW = 8 + WIN_LOG2;
    localparam int CW = WIN_LOG2 + 1;

    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [SW-1:0]       acc_sum_q, acc_sum_d;
    logic [7:0]          acc_min_q, acc_min_d;
    logic [7:0]          acc_max_q, acc_max_d;
    logic [CW-1:0]       acc_chg_q, acc_chg_d;
    logic [7:0]          prev_q;
    logic                prev_ok_q;
    logic                first_smp, last_smp, changed;

    logic [SW-1:0] sum_q;
    logic [7:0]    min_q, max_q, avg_q;
    logic [CW-1:0] chg_q;
    logic          valid_q;

    // prev_ok gates the change count so the first sample after reset never counts.
    always_comb begin
        first_smp = (cnt_q == '0);
        last_smp  = (cnt_q == {WIN_LOG2{1'b1}});
        changed   = prev_ok_q && (pi_a != prev_q);
        cnt_d     = cnt_q + WIN_LOG2'(1);
        acc_sum_d = SW'(pi_a);
        acc_min_d = pi_a;
        acc_max_d = pi_a;
        acc_chg_d = {{WIN_LOG2{1'b0}}, changed};
        if (!first_smp) begin
            acc_sum_d = acc_sum_q + SW'(pi_a);
            acc_min_d = (pi_a < acc_min_q) ? pi_a : acc_min_q;
            acc_max_d = (pi_a > acc_max_q) ? pi_a : acc_max_q;
            acc_chg_d = acc_chg_q + {{WIN_LOG2{1'b0}}, changed};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            acc_sum_q <= '0;
            acc_min_q <= '0;
            acc_max_q <= '0;
            acc_chg_q <= '0;
            prev_q    <= '0;
            prev_ok_q <= 1'b0;
            sum_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            avg_q     <= '0;
            chg_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (pi_en) begin
                cnt_q     <= cnt_d;
                acc_sum_q <= acc_sum_d;
                acc_min_q <= acc_min_d;
                acc_max_q <= acc_max_d;
                acc_chg_q <= acc_chg_d;
                prev_q    <= pi_a;
                prev_ok_q <= 1'b1;
                // Results include the closing sample, so they come from the next-state values.
                if (last_smp) begin
                    sum_q   <= acc_sum_d;
                    min_q   <= acc_min_d;
                    max_q   <= acc_max_d;
                    avg_q   <= acc_sum_d[SW-1 -: 8];
                    chg_q   <= acc_chg_d;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign po_sum   = sum_q;
    assign po_min   = min_q;
    assign po_max   = max_q;
    assign po_avg   = avg_q;
    assign po_chg   = chg_q;
    assign po_valid = valid_q;

endmodule

// File: tb/tb_operaters_stat.sv
// Directed-vector bench for operaters_stat with N=8 windows and hand-computed results.
module tb_operaters_stat;

    logic        clk;
    logic        rst;
    logic        pi_en;
    logic [7:0]  pi_a;
    logic [10:0] po_sum;
    logic [7:0]  po_min, po_max, po_avg;
    logic [3:0]  po_chg;
    logic        po_valid;

    int checks;
    int errors;
    int pulses;
    int cyc;
    int pulse_cyc[$];

    operaters_stat #(.WIN_LOG2(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .pi_en    (pi_en),
        .pi_a     (pi_a),
        .po_sum   (po_sum),
        .po_min   (po_min),
        .po_max   (po_max),
        .po_avg   (po_avg),
        .po_chg   (po_chg),
        .po_valid (po_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // One clock edge with the given inputs; outputs sampled 1 ns after the edge.
    task automatic step(input logic en, input logic [7:0] a);
        pi_en = en;
        pi_a  = a;
        @(posedge clk);
        #1;
        cyc++;
        if (po_valid) begin
            pulses++;
            pulse_cyc.push_back(cyc);
        end
    endtask

    task automatic check_results(input string tag, input int s, input int mn, input int mx,
                                 input int av, input int ch);
        check({tag, ".sum"}, 32'(po_sum), s);
        check({tag, ".min"}, 32'(po_min), mn);
        check({tag, ".max"}, 32'(po_max), mx);
        check({tag, ".avg"}, 32'(po_avg), av);
        check({tag, ".chg"}, 32'(po_chg), ch);
    endtask

    task automatic do_reset(input int n);
        #2;
        rst = 1'b0;
        for (int i = 0; i < n; i++) step(1'b1, 8'($urandom_range(0, 255)));
        rst = 1'b1;
        pulses = 0;
        pulse_cyc.delete();
    endtask

    logic [10:0] h_sum;
    logic [7:0]  h_min, h_max, h_avg;
    logic [3:0]  h_chg;
    int          stable_bad;

    initial begin
        checks = 0; errors = 0; pulses = 0; cyc = 0;
        rst = 1'b1; pi_en = 1'b0; pi_a = 8'd0;
        @(posedge clk); #1;

        // Reset with random traffic: outputs stay 0 and no pulse.
        #2; rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 255)));
        check("reset.pulses", pulses, 0);
        check_results("reset", 0, 0, 0, 0, 0);
        check("reset.valid", 32'(po_valid), 0);
        rst = 1'b1; pulses = 0; pulse_cyc.delete();

        // Ramp 1..8.
        for (int i = 1; i <= 7; i++) step(1'b1, 8'(i));
        check("ramp.no_early_pulse", pulses, 0);
        step(1'b1, 8'd8);
        check("ramp.valid", 32'(po_valid), 1);
        check_results("ramp", 36, 1, 8, 4, 7);
        step(1'b0, 8'd99);
        check("ramp.valid_drop", 32'(po_valid), 0);
        check("ramp.pulses", pulses, 1);

        // Saturation right after reset.
        do_reset(2);
        for (int i = 0; i < 8; i++) step(1'b1, 8'hFF);
        check("sat.valid", 32'(po_valid), 1);
        check_results("sat", 11'h7F8, 255, 255, 255, 0);

        // Qualifier gaps, then 20 idle cycles with outputs held.
        do_reset(2);
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) step(1'b1, 8'd10);
            else            step(1'b0, 8'd0);
        end
        check("gap.pulses", pulses, 1);
        if (pulse_cyc.size() == 1) check("gap.pulse_pos", pulse_cyc[0] - (cyc - 16), 15);
        check_results("gap", 80, 10, 10, 10, 0);
        h_sum = po_sum; h_min = po_min; h_max = po_max; h_avg = po_avg; h_chg = po_chg;
        stable_bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'($urandom_range(0, 255)));
            if (po_sum !== h_sum || po_min !== h_min || po_max !== h_max ||
                po_avg !== h_avg || po_chg !== h_chg) stable_bad++;
        end
        check("hold.changed_cycles", stable_bad, 0);
        check("hold.pulses", pulses, 1);
        check_results("hold", 80, 10, 10, 10, 0);

        // Back-to-back windows; first 8 of window 2 matches prev.
        do_reset(2);
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i));
        check_results("b2b.w1", 36, 1, 8, 4, 7);
        for (int i = 8; i >= 1; i--) step(1'b1, 8'(i));
        check("b2b.valid", 32'(po_valid), 1);
        check_results("b2b.w2", 36, 1, 8, 4, 7);
        check("b2b.pulses", pulses, 2);
        if (pulse_cyc.size() == 2) check("b2b.spacing", pulse_cyc[1] - pulse_cyc[0], 8);

        // Mid-window reset discards the partial window.
        do_reset(2);
        for (int i = 0; i < 5; i++) step(1'b1, 8'd200);
        #2; rst = 1'b0; #1;
        check("mid.async_sum", 32'(po_sum), 0);
        step(1'b1, 8'd200);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 8'd2);
        check("mid.pulses", pulses, 1);
        check("mid.valid", 32'(po_valid), 1);
        check_results("mid", 16, 2, 2, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
